// File: rtl/ex_idiv_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Optional macro IDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module ex_idiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_op;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_signed;
  logic            w_b_zero;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_fix_val;

  assign w_accept = (r_state == S_IDLE) & start & funct3[2] & ~flush;
  assign w_signed = ~funct3[0];
  assign w_b_zero = (rs2_val == '0);
  // The most negative value negates to itself, which is exactly its unsigned magnitude.
  assign w_a_mag  = (w_signed & rs1_val[XLEN-1]) ? (-rs1_val) : rs1_val;
  assign w_b_mag  = (w_signed & rs2_val[XLEN-1]) ? (-rs2_val) : rs2_val;

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[XLEN];
  assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];

  assign w_fix_val = r_op ? (r_neg_r ? (-r_rem) : r_rem)
                          : (r_neg_q ? (-r_quo) : r_quo);

`ifdef IDIV_EARLY_OUT_EN
  logic            w_early;
  logic [XLEN-1:0] w_early_val;
  assign w_early = w_b_zero |
                   (w_signed & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1));
  // Overflow quotient equals the dividend itself (0x80000000).
  assign w_early_val = w_b_zero ? (funct3[1] ? rs1_val : '1)
                                : (funct3[1] ? '0 : rs1_val);
`endif

  assign stall  = ~RST & (((r_state == S_IDLE) & start & funct3[2]) |
                          (r_state == S_ITER) | (r_state == S_FIX));
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef IDIV_EARLY_OUT_EN
          w_next = w_early ? S_DONE : S_ITER;
`else
          w_next = S_ITER;
`endif
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ITER: begin
        if (flush)              w_next = S_IDLE;
        else if (r_cnt == '0)   w_next = S_FIX;
        else                    w_next = S_ITER;
      end
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_op     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= (w_next == S_ITER) | (w_next == S_FIX);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_cnt   <= CW'(XLEN - 1);
            r_neg_q <= w_signed & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]) & ~w_b_zero;
            r_neg_r <= w_signed & rs1_val[XLEN-1];
            r_op    <= funct3[1];
`ifdef IDIV_EARLY_OUT_EN
            if (w_early) r_result <= w_early_val;
`endif
          end
        end
        S_ITER: begin
          if (!flush) begin
            r_rem <= w_rem_nx;
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (!flush) r_result <= w_fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule
